pc_gen_unit: RTL and testbench
==============================

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 'h100, PC loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter IALIGN, default 4, instruction alignment in bytes; legal values 2 or 4.
REQ-005 SHALL have parameter BOOT_DELAY, default 2, cycles held in BOOT before fetching; range 0..15.
REQ-006 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port stall  input  1  hold PC; blocks sequential advance only.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-010 SHALL have port redirect_target  input  XLEN  redirect destination.
REQ-011 SHALL have port trap_valid  input  1  trap request.
REQ-012 SHALL have port halt_req  input  1  enter HALT.
REQ-013 SHALL have port resume_req  input  1  leave HALT.
REQ-014 SHALL have port fetch_ready  input  1  instruction memory accepts current pc.
REQ-015 SHALL have port pc  output  XLEN  current fetch address (registered).
REQ-016 SHALL have port pc_next_seq  output  XLEN  pc + IALIGN, combinational, modulo 2^XLEN.
REQ-017 SHALL have port fetch_valid  output  1  pc is a valid fetch request.
REQ-018 SHALL have port misalign_trap  output  1  one-cycle pulse on misaligned redirect.
REQ-019 SHALL have port bad_addr  output  XLEN  last misaligned target (registered).
REQ-020 SHALL have port state  output  2  BOOT=00, RUN=01, HALT=10.
REQ-021 SHALL have port fetch_count  output  32  accepted-fetch counter.

Function
REQ-022 SHALL implement states BOOT, RUN, HALT; 11 unreachable, decoded as BOOT.
REQ-023 BOOT: fetch_valid=0, pc held; after BOOT_DELAY cycles -> RUN; BOOT_DELAY=0 -> RUN on first edge after reset release; all requests ignored in BOOT.
REQ-024 RUN: fetch_valid=1; fetch accepted when fetch_valid & fetch_ready & !stall.
REQ-025 RUN per-cycle priority, highest first: trap_valid > redirect_valid > halt_req > accepted fetch (pc <= pc_next_seq) > hold.
REQ-026 trap_valid in RUN: pc <= TRAP_VECTOR next cycle, regardless of stall and fetch_ready.
REQ-027 redirect_valid in RUN, target aligned: pc <= redirect_target next cycle, regardless of stall and fetch_ready.
REQ-028 Misaligned: target bits [log2(IALIGN)-1:0] != 0; then pc <= TRAP_VECTOR, bad_addr <= target, misalign_trap=1 for exactly the next cycle.
REQ-029 halt_req in RUN, no trap/redirect: -> HALT next cycle, pc held, no fetch counted that cycle.
REQ-030 HALT: fetch_valid=0; resume_req -> RUN next cycle, pc unchanged.
REQ-031 HALT + redirect_valid: pc <= target (misalignment check per REQ-028), remain HALT unless resume_req also high.
REQ-032 HALT + trap_valid: pc <= TRAP_VECTOR, -> RUN next cycle; trap beats resume_req and redirect.
REQ-033 pc increment SHALL wrap modulo 2^XLEN (all-ones-region pc + IALIGN -> low address).
REQ-034 fetch_count SHALL increment by 1 per accepted fetch, saturating at 32'hFFFF_FFFF.
REQ-035 Simultaneous trap_valid and redirect_valid: trap wins; redirect discarded, no misalign_trap.

Reset
REQ-036 reset asserted SHALL force immediately, without clk: pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misalign_trap=0, bad_addr=0, fetch_count=0, boot counter=0.
REQ-037 reset mid-operation SHALL discard any pending redirect, trap, or halt; BOOT restarts full BOOT_DELAY after release.

Verification
REQ-038 Reset, BOOT_DELAY=2, fetch_ready=1 -> fetch_valid 0 for 2 cycles, then pc 0,4,8,C on successive cycles; fetch_count=4.
REQ-039 RUN at pc=8, stall=1 and redirect_valid=1 target 'h40 -> next pc='h40; stall alone -> pc holds 8, count frozen.
REQ-040 redirect target 'h42, IALIGN=4 -> pc='h100, misalign_trap one-cycle pulse, bad_addr='h42; IALIGN=2 -> pc='h42, no pulse.
REQ-041 trap_valid and redirect_valid same cycle -> pc='h100, no misalign_trap; halt_req -> state=10, fetch_valid=0; resume_req -> state=01, pc unchanged.
REQ-042 pc='hFFFF_FFFC, accepted fetch -> pc=0; reset pulse mid-RUN -> pc=0, state=00, fetch_count=0 before next clk edge.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing with trap, redirect and misalignment handling.
// All outputs except pc_next_seq are registered; stall only blocks the sequential advance.
module pc_gen_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h100),
  parameter int                IALIGN       = 4,
  parameter int                BOOT_DELAY   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            fetch_valid,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_addr,
  output logic [1:0]      state,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fetch_valid;
  logic            r_misalign;
  logic [XLEN-1:0] r_bad_addr;
  logic [31:0]     r_fetch_count;
  logic [3:0]      r_boot_cnt;

  logic [XLEN-1:0] w_pc_next_seq;
  logic            w_misaligned;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_accept;
  logic            w_boot_done;

  assign w_pc_next_seq = r_pc + XLEN'(IALIGN);
  assign w_misaligned  = |(redirect_target & ALIGN_MASK);
  assign w_redir_pc    = w_misaligned ? TRAP_VECTOR : redirect_target;
  assign w_accept      = r_fetch_valid & fetch_ready & ~stall;
  // The edge that completes BOOT_DELAY cycles moves to RUN; BOOT_DELAY=0 leaves on the first edge.
  assign w_boot_done   = ({1'b0, r_boot_cnt} + 5'd1) >= 5'(BOOT_DELAY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_bad_addr    <= '0;
      r_fetch_count <= '0;
      r_boot_cnt    <= '0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (trap_valid) begin
            r_pc <= TRAP_VECTOR;
          end else if (redirect_valid) begin
            r_pc <= w_redir_pc;
            if (w_misaligned) begin
              r_misalign <= 1'b1;
              r_bad_addr <= redirect_target;
            end
          end else if (halt_req) begin
            r_state       <= S_HALT;
            r_fetch_valid <= 1'b0;
          end else if (w_accept) begin
            r_pc <= w_pc_next_seq;
            if (r_fetch_count != '1) r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        S_HALT: begin
          if (trap_valid) begin
            r_pc          <= TRAP_VECTOR;
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
          end else begin
            if (redirect_valid) begin
              r_pc <= w_redir_pc;
              if (w_misaligned) begin
                r_misalign <= 1'b1;
                r_bad_addr <= redirect_target;
              end
            end
            if (resume_req) begin
              r_state       <= S_RUN;
              r_fetch_valid <= 1'b1;
            end
          end
        end
        default: begin
          // BOOT, and the unused 2'b11 encoding, ignore every request.
          if (w_boot_done) begin
            r_state       <= S_RUN;
            r_fetch_valid <= 1'b1;
            r_boot_cnt    <= '0;
          end else begin
            r_boot_cnt <= r_boot_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign pc_next_seq   = w_pc_next_seq;
  assign fetch_valid   = r_fetch_valid;
  assign misalign_trap = r_misalign;
  assign bad_addr      = r_bad_addr;
  assign state         = r_state;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: table of per-cycle stimulus/expectations through a scoreboard queue,
// plus an async mid-run reset sequence and an IALIGN=2 instance sharing the same stimulus.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, trap_valid, halt_req, resume_req, fetch_ready;
  logic [31:0] redirect_target;

  logic [31:0] a_pc, a_pc_next_seq, a_bad_addr, a_fetch_count;
  logic        a_fetch_valid, a_misalign_trap;
  logic [1:0]  a_state;
  logic [31:0] b_pc, b_pc_next_seq, b_bad_addr, b_fetch_count;
  logic        b_fetch_valid, b_misalign_trap;
  logic [1:0]  b_state;

  always #5 clk = ~clk;

  pc_gen_unit dut_a (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid), .halt_req(halt_req),
    .resume_req(resume_req), .fetch_ready(fetch_ready), .pc(a_pc), .pc_next_seq(a_pc_next_seq),
    .fetch_valid(a_fetch_valid), .misalign_trap(a_misalign_trap), .bad_addr(a_bad_addr),
    .state(a_state), .fetch_count(a_fetch_count)
  );

  pc_gen_unit #(.IALIGN(2)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid), .halt_req(halt_req),
    .resume_req(resume_req), .fetch_ready(fetch_ready), .pc(b_pc), .pc_next_seq(b_pc_next_seq),
    .fetch_valid(b_fetch_valid), .misalign_trap(b_misalign_trap), .bad_addr(b_bad_addr),
    .state(b_state), .fetch_count(b_fetch_count)
  );

  // ctl = {stall, redirect_valid, trap_valid, halt_req, resume_req, fetch_ready}
  // flg = {state[1:0], fetch_valid, misalign_trap}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [3:0]  flg;
    logic [31:0] bad;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[27];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [5:0] c, input logic [31:0] t, input logic [31:0] p,
                              input logic [3:0] f, input logic [31:0] b, input logic [31:0] n);
    vec_t v;
    v.ctl = c; v.tgt = t; v.pc = p; v.flg = f; v.bad = b; v.cnt = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {stall, redirect_valid, trap_valid, halt_req, resume_req, fetch_ready} = v.ctl;
    redirect_target = v.tgt;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input int i);
    vec_t e;
    drive(vecs[i]);
    sb.push_back(vecs[i]);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d pc", i),          a_pc,                   e.pc);
    check($sformatf("v%0d pc_next_seq", i), a_pc_next_seq,          e.pc + 32'd4);
    check($sformatf("v%0d state", i),       {30'd0, a_state},       {30'd0, e.flg[3:2]});
    check($sformatf("v%0d fetch_valid", i), {31'd0, a_fetch_valid}, {31'd0, e.flg[1]});
    check($sformatf("v%0d misalign", i),    {31'd0, a_misalign_trap}, {31'd0, e.flg[0]});
    check($sformatf("v%0d bad_addr", i),    a_bad_addr,             e.bad);
    check($sformatf("v%0d fetch_count", i), a_fetch_count,          e.cnt);
    if (i == 10) begin
      // IALIGN=2 accepts 'h42 as an aligned redirect target.
      check("b align2 pc",       b_pc,                     32'h42);
      check("b align2 next_seq", b_pc_next_seq,            32'h44);
      check("b align2 misalign", {31'd0, b_misalign_trap}, 32'd0);
      check("b align2 bad_addr", b_bad_addr,               32'd0);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pc"},          a_pc,                     32'd0);
    check({tag, " state"},       {30'd0, a_state},         32'd0);
    check({tag, " fetch_valid"}, {31'd0, a_fetch_valid},   32'd0);
    check({tag, " misalign"},    {31'd0, a_misalign_trap}, 32'd0);
    check({tag, " bad_addr"},    a_bad_addr,               32'd0);
    check({tag, " fetch_count"}, a_fetch_count,            32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(6'b000001, 32'h0,        32'h0,        4'b0000, 32'h0,  32'd0); // BOOT cycle 1
    vecs[1]  = mk(6'b000001, 32'h0,        32'h0,        4'b0110, 32'h0,  32'd0); // enter RUN
    vecs[2]  = mk(6'b000001, 32'h0,        32'h4,        4'b0110, 32'h0,  32'd1);
    vecs[3]  = mk(6'b000001, 32'h0,        32'h8,        4'b0110, 32'h0,  32'd2);
    vecs[4]  = mk(6'b000001, 32'h0,        32'hC,        4'b0110, 32'h0,  32'd3);
    vecs[5]  = mk(6'b000001, 32'h0,        32'h10,       4'b0110, 32'h0,  32'd4);
    vecs[6]  = mk(6'b010001, 32'h8,        32'h8,        4'b0110, 32'h0,  32'd4); // redirect back to 8
    vecs[7]  = mk(6'b100001, 32'h0,        32'h8,        4'b0110, 32'h0,  32'd4); // stall holds
    vecs[8]  = mk(6'b110001, 32'h40,       32'h40,       4'b0110, 32'h0,  32'd4); // redirect beats stall
    vecs[9]  = mk(6'b000000, 32'h0,        32'h40,       4'b0110, 32'h0,  32'd4); // not ready
    vecs[10] = mk(6'b010001, 32'h42,       32'h100,      4'b0111, 32'h42, 32'd4); // misaligned
    vecs[11] = mk(6'b000001, 32'h0,        32'h104,      4'b0110, 32'h42, 32'd5); // pulse ends
    vecs[12] = mk(6'b011001, 32'h42,       32'h100,      4'b0110, 32'h42, 32'd5); // trap beats redirect
    vecs[13] = mk(6'b000101, 32'h0,        32'h100,      4'b1000, 32'h42, 32'd5); // halt
    vecs[14] = mk(6'b000001, 32'h0,        32'h100,      4'b1000, 32'h42, 32'd5); // no fetch in HALT
    vecs[15] = mk(6'b010000, 32'h200,      32'h200,      4'b1000, 32'h42, 32'd5); // HALT redirect
    vecs[16] = mk(6'b000010, 32'h0,        32'h200,      4'b0110, 32'h42, 32'd5); // resume
    vecs[17] = mk(6'b000100, 32'h0,        32'h200,      4'b1000, 32'h42, 32'd5);
    vecs[18] = mk(6'b011010, 32'h44,       32'h100,      4'b0110, 32'h42, 32'd5); // trap wins in HALT
    vecs[19] = mk(6'b010001, 32'hFFFFFFFC, 32'hFFFFFFFC, 4'b0110, 32'h42, 32'd5);
    vecs[20] = mk(6'b000001, 32'h0,        32'h0,        4'b0110, 32'h42, 32'd6); // wrap
    vecs[21] = mk(6'b000101, 32'h0,        32'h0,        4'b1000, 32'h42, 32'd6); // halt over fetch
    vecs[22] = mk(6'b010000, 32'h3,        32'h100,      4'b1001, 32'h3,  32'd6); // misaligned in HALT
    vecs[23] = mk(6'b000010, 32'h0,        32'h100,      4'b0110, 32'h3,  32'd6);
    vecs[24] = mk(6'b011101, 32'h40,       32'h0,        4'b0000, 32'h0,  32'd0); // ignored in BOOT
    vecs[25] = mk(6'b010001, 32'h40,       32'h0,        4'b0110, 32'h0,  32'd0);
    vecs[26] = mk(6'b000001, 32'h0,        32'h4,        4'b0110, 32'h0,  32'd1);

    reset = 1'b1;
    drive(mk(6'b000000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'd0));
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) apply(i);

    // Asynchronous reset mid-RUN takes effect before the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("midrun reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 24; i < 27; i++) apply(i);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
